// File: rtl/recovery_ctrl.sv
// ---------------------------------------------------------------------------
// recovery_ctrl
// Rollback-recovery sequencer for the fault-tolerant core pair. When an
// error is flagged it halts the cores and waits for their halt acknowledge.
// It then shifts the special-purpose register chain for NUM_SPC cycles and
// replays NUM_REG GPR addresses over a valid/ready handshake. Finally it
// pulses resume for one cycle.
// An error that arrives mid-recovery restarts the sequence. After MAX_RETRY
// restarts a further error parks the block in a sticky FAIL state, which
// only rst_i clears.
//
// Ports
//   clk_i          : clock, all state changes on the rising edge
//   rst_i          : asynchronous active-high reset
//   error_i        : error level from the checker
//   halted_i       : cores report halted
//   replay_ready_i : copy port accepts the current address
//   halt_o         : halt request (HALT, SPC, GPR, FAIL)
//   shift_o        : SPR chain shift enable (SPC)
//   replay_valid_o : replay_addr_o valid (GPR)
//   replay_addr_o  : GPR address being replayed
//   resume_o       : one-cycle resume pulse (DONE)
//   busy_o         : recovery in progress (HALT, SPC, GPR, DONE)
//   fail_o         : sticky failure flag (FAIL)
//   retry_cnt_o    : restarts taken in the current event
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an error
// HALT  | halt requested, waiting for halted_i
// SPC   | shifting special-purpose words, NUM_SPC cycles
// GPR   | replaying GPR addresses 0..NUM_REG-1 over valid/ready
// DONE  | one-cycle resume pulse
// FAIL  | retries exhausted, cores held halted until reset
// ---------------------------------------------------------------------------
module recovery_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REG    = 2**ADDR_WIDTH,
  parameter int NUM_SPC    = 2,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic                  halted_i,
  input  logic                  replay_ready_i,
  output logic                  halt_o,
  output logic                  shift_o,
  output logic                  replay_valid_o,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic                  resume_o,
  output logic                  busy_o,
  output logic                  fail_o,
  output logic [RETRY_W-1:0]    retry_cnt_o
);

  localparam int SPC_W = (NUM_SPC > 1) ? $clog2(NUM_SPC) : 1;
  localparam logic [SPC_W-1:0]      SPC_LAST  = SPC_W'(NUM_SPC - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REG - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);

  // One-hot so every output decode below is a plain OR of flop bits.
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_HALT = 6'b000010,
    S_SPC  = 6'b000100,
    S_GPR  = 6'b001000,
    S_DONE = 6'b010000,
    S_FAIL = 6'b100000
  } state_t;

  state_t                r_state;
  logic [SPC_W-1:0]      r_spc;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [RETRY_W-1:0]    r_retry;
  logic                  w_in_seq;

  // States in which an error restarts (or aborts) the sequence.
  assign w_in_seq = (r_state == S_HALT) || (r_state == S_SPC) || (r_state == S_GPR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_spc   <= '0;
      r_addr  <= '0;
      r_retry <= '0;
    end else if (w_in_seq && error_i) begin
      // The error takes priority over whatever the current state would do.
      if (r_retry == RETRY_MAX) begin
        r_state <= S_FAIL;
      end else begin
        r_retry <= r_retry + RETRY_W'(1);
        r_spc   <= '0;
        r_addr  <= '0;
        r_state <= S_HALT;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (error_i) begin
            r_retry <= '0;
            r_spc   <= '0;
            r_addr  <= '0;
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (halted_i) begin
            r_spc   <= '0;
            r_state <= S_SPC;
          end
        end
        S_SPC: begin
          if (r_spc == SPC_LAST) begin
            r_addr  <= '0;
            r_state <= S_GPR;
          end else begin
            r_spc <= r_spc + SPC_W'(1);
          end
        end
        S_GPR: begin
          // Terminal compare before the increment, so a full-range
          // NUM_REG never wraps the address counter.
          if (replay_ready_i) begin
            if (r_addr == ADDR_LAST) r_state <= S_DONE;
            else                     r_addr  <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DONE: begin
          // An error seen while resuming starts a fresh event.
          if (error_i) begin
            r_retry <= '0;
            r_spc   <= '0;
            r_addr  <= '0;
            r_state <= S_HALT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FAIL:  r_state <= S_FAIL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign halt_o         = (r_state == S_HALT) || (r_state == S_SPC) ||
                          (r_state == S_GPR)  || (r_state == S_FAIL);
  assign shift_o        = (r_state == S_SPC);
  assign replay_valid_o = (r_state == S_GPR);
  assign resume_o       = (r_state == S_DONE);
  assign busy_o         = (r_state == S_HALT) || (r_state == S_SPC) ||
                          (r_state == S_GPR)  || (r_state == S_DONE);
  assign fail_o         = (r_state == S_FAIL);
  assign replay_addr_o  = r_addr;
  assign retry_cnt_o    = r_retry;

endmodule
